// File: rtl/emergency_arbiter.sv
// Emergency-vehicle preemption arbiter: latches request rises, grants one
// direction at a time round-robin, bounds each grant and inserts an
// all-clear gap before the next one.
module emergency_arbiter #(
    parameter int unsigned HOLD_CYCLES  = 20,
    parameter int unsigned MAX_GRANT    = 60,
    parameter int unsigned CLEAR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [3:0] emg_req,
    input  logic [3:0] emg_done,
    output logic [3:0] emergency_dir,
    output logic       grant_valid,
    output logic       busy,
    output logic [3:0] pending,
    output logic       timeout
);

    // The same counter times both the grant and the all-clear gap.
    localparam int unsigned CNT_MAX = (MAX_GRANT > CLEAR_CYCLES) ? MAX_GRANT : CLEAR_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] MAX_LAST   = CW'(MAX_GRANT - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_CLEAR = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      dir_q, dir_d;
    logic [3:0]      pending_q, pending_d;
    logic [3:0]      req_prev_q, req_prev_d;
    logic [1:0]      last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_seen_q, done_seen_d;
    logic            timeout_q, timeout_d;
    logic            busy_q, busy_d;
    logic            grant_valid_q, grant_valid_d;

    logic [3:0]      rise_c;
    logic [1:0]      win_idx_c;
    logic [3:0]      win_oh_c;
    logic            done_g_c;
    logic            hold_met_c;
    logic            max_hit_c;
    logic            clear_last_c;

    // Request rise detection and grant-termination conditions.
    always_comb begin
        rise_c       = emg_req & ~req_prev_q;
        done_g_c     = |(emg_done & dir_q);
        hold_met_c   = (cnt_q >= HOLD_LAST) && (done_seen_q || done_g_c);
        max_hit_c    = (cnt_q == MAX_LAST);
        clear_last_c = (cnt_q == CLEAR_LAST);
    end

    // Round-robin pick: first pending bit after last; scanning from the far
    // end lets the nearest candidate overwrite the others.
    always_comb begin
        win_idx_c = last_q;
        for (int i = 4; i >= 1; i--) begin
            if (pending_q[2'(last_q + 2'(i))]) begin
                win_idx_c = 2'(last_q + 2'(i));
            end
        end
        win_oh_c = 4'b0001 << win_idx_c;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (hold_met_c || max_hit_c) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clear_last_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values for the current state.
    always_comb begin
        dir_d       = dir_q;
        pending_d   = pending_q | rise_c;
        req_prev_d  = emg_req;
        last_d      = last_q;
        cnt_d       = cnt_q;
        done_seen_d = done_seen_q;
        timeout_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    // A same-cycle rise on the winner is absorbed by the grant.
                    pending_d   = (pending_q | rise_c) & ~win_oh_c;
                    dir_d       = win_oh_c;
                    last_d      = win_idx_c;
                    cnt_d       = '0;
                    done_seen_d = 1'b0;
                end
            end
            S_GRANT: begin
                // Re-request from the vehicle already being served is dropped.
                pending_d = pending_q | (rise_c & ~dir_q);
                if (hold_met_c || max_hit_c) begin
                    dir_d       = 4'b0000;
                    cnt_d       = '0;
                    done_seen_d = 1'b0;
                    timeout_d   = !hold_met_c;
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                    done_seen_d = done_seen_q | done_g_c;
                end
            end
            S_CLEAR: begin
                dir_d = 4'b0000;
                if (clear_last_c) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                dir_d = 4'b0000;
                cnt_d = '0;
            end
        endcase

        busy_d        = (state_d != S_IDLE);
        grant_valid_d = |dir_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            dir_q         <= 4'b0000;
            pending_q     <= 4'b0000;
            req_prev_q    <= 4'b0000;
            last_q        <= 2'd3;
            cnt_q         <= '0;
            done_seen_q   <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
            grant_valid_q <= 1'b0;
        end else begin
            dir_q         <= dir_d;
            pending_q     <= pending_d;
            req_prev_q    <= req_prev_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            done_seen_q   <= done_seen_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign emergency_dir = dir_q;
    assign grant_valid   = grant_valid_q;
    assign busy          = busy_q;
    assign pending       = pending_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_emergency_arbiter.sv
// Self-checking bench for emergency_arbiter: directed scenarios plus random
// traffic, all compared against a grant/gap level reference model.
module tb_emergency_arbiter;

    localparam int HOLD = 20;
    localparam int MAXG = 60;
    localparam int CLR  = 3;

    logic       clk;
    logic       rst_a;
    logic [3:0] emg_req;
    logic [3:0] emg_done;
    logic [3:0] emergency_dir;
    logic       grant_valid;
    logic       busy;
    logic [3:0] pending;
    logic       timeout;

    emergency_arbiter #(
        .HOLD_CYCLES (HOLD),
        .MAX_GRANT   (MAXG),
        .CLEAR_CYCLES(CLR)
    ) dut (
        .clk          (clk),
        .rst_a        (rst_a),
        .emg_req      (emg_req),
        .emg_done     (emg_done),
        .emergency_dir(emergency_dir),
        .grant_valid  (grant_valid),
        .busy         (busy),
        .pending      (pending),
        .timeout      (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: which direction is being served (-1 none), how long it
    // has been served, when its done was first seen, and the clear gap left.
    int       m_g    = -1;
    int       m_age  = 0;
    int       m_k    = -1;
    int       m_gap  = 0;
    int       m_last = 3;
    bit [3:0] m_pend = '0;
    bit [3:0] m_prev = '0;
    bit       m_to   = 1'b0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            m_g = -1; m_age = 0; m_k = -1; m_gap = 0; m_last = 3;
            m_pend = '0; m_prev = '0; m_to = 1'b0;
        end else begin
            bit [3:0] rise;
            int g_old;
            int w;
            rise  = emg_req & ~m_prev;
            g_old = m_g;
            m_to  = 1'b0;
            if (m_g >= 0) begin
                if (m_k < 0 && emg_done[m_g]) m_k = m_age;
                if (m_k >= 0 && m_age + 1 >= imax(HOLD, m_k + 1)) begin
                    m_g = -1; m_gap = CLR;
                end else if (m_age + 1 == MAXG) begin
                    m_g = -1; m_gap = CLR; m_to = 1'b1;
                end else begin
                    m_age++;
                end
                for (int i = 0; i < 4; i++) if (rise[i] && i != g_old) m_pend[i] = 1'b1;
            end else if (m_gap > 0) begin
                m_gap--;
                m_pend |= rise;
            end else begin
                w = -1;
                for (int j = 1; j <= 4; j++) begin
                    int c;
                    c = (m_last + j) % 4;
                    if (w < 0 && m_pend[c]) w = c;
                end
                m_pend |= rise;
                if (w >= 0) begin
                    m_pend[w] = 1'b0;
                    m_g = w; m_age = 0; m_k = -1; m_last = w;
                end
            end
            m_prev = emg_req;
        end
    end

    // Per-cycle comparison plus grant order / length / gap bookkeeping.
    bit         chk_en   = 1'b0;
    logic [3:0] prev_dir = 4'b0000;
    int         cur_len  = 0;
    int         last_len = 0;
    int         zero_run = 0;
    int         last_gap = 0;
    int         to_count = 0;
    logic [3:0] grant_log[$];

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] e_dir;
            e_dir = (m_g >= 0) ? 4'(1 << m_g) : 4'b0000;
            chk("dir",     32'(emergency_dir), 32'(e_dir));
            chk("gvalid",  32'(grant_valid),   32'(m_g >= 0));
            chk("busy",    32'(busy),          32'(m_g >= 0 || m_gap > 0));
            chk("pending", 32'(pending),       32'(m_pend));
            chk("timeout", 32'(timeout),       32'(m_to));

            if (emergency_dir != 4'b0000 && prev_dir == 4'b0000) begin
                grant_log.push_back(emergency_dir);
                last_gap = zero_run;
                cur_len  = 1;
            end else if (emergency_dir != 4'b0000) begin
                cur_len++;
            end
            if (emergency_dir == 4'b0000 && prev_dir != 4'b0000) last_len = cur_len;
            zero_run = (emergency_dir == 4'b0000) ? zero_run + 1 : 0;
            if (timeout) to_count++;
            prev_dir = emergency_dir;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_dir(input logic [3:0] want, input int budget);
        int n;
        n = 0;
        while (emergency_dir !== want && n < budget) begin
            step();
            n++;
        end
        chk("wait_dir", 32'(emergency_dir), 32'(want));
    endtask

    initial begin
        int n_grants;
        emg_req  = 4'b0000;
        emg_done = 4'b0000;
        rst_a    = 1'b1;

        // Reset asserted between edges takes effect immediately.
        #3 rst_a = 1'b0;
        #1;
        chk("rst_dir",  32'(emergency_dir), 32'h0);
        chk("rst_gv",   32'(grant_valid),   32'h0);
        chk("rst_busy", 32'(busy),          32'h0);
        chk("rst_pend", 32'(pending),       32'h0);
        chk("rst_to",   32'(timeout),       32'h0);
        chk_en = 1'b1;
        step();
        rst_a = 1'b1;
        repeat (50) step();
        chk("idle_dir", 32'(emergency_dir), 32'h0);

        // Single S request, done pulsed in grant cycle 5.
        emg_req = 4'b0010;
        step();
        emg_req = 4'b0000;
        wait_dir(4'b0010, 5);
        repeat (4) step();
        emg_done = 4'b0010;
        step();
        emg_done = 4'b0000;
        wait_dir(4'b0000, 40);
        chk("s_len", 32'(last_len), 32'd20);
        chk("s_noto", 32'(to_count), 32'd0);
        repeat (2) step();
        chk("s_busy_clr", 32'(busy), 32'd1);
        step();
        chk("s_busy_idle", 32'(busy), 32'd0);

        // E request never cleared: bounded by the maximum grant.
        emg_req = 4'b0100;
        step();
        emg_req = 4'b0000;
        wait_dir(4'b0100, 5);
        wait_dir(4'b0000, 70);
        chk("to_len", 32'(last_len), 32'd60);
        chk("to_pulse", 32'(timeout), 32'd1);
        step();
        chk("to_drop", 32'(timeout), 32'd0);

        // N+E high out of reset, then S+W: expect N, E, W, S.
        #1 rst_a = 1'b0;
        emg_req  = 4'b0101;
        emg_done = 4'b1111;
        step();
        rst_a = 1'b1;
        grant_log.delete();
        wait_dir(4'b0001, 5);
        wait_dir(4'b0100, 40);
        chk("rr_gap", 32'(last_gap), 32'd4);
        emg_req = 4'b0000;
        wait_dir(4'b0000, 40);
        repeat (5) step();
        emg_req = 4'b1010;
        step();
        emg_req = 4'b0000;
        wait_dir(4'b1000, 10);
        wait_dir(4'b0010, 40);
        wait_dir(4'b0000, 40);
        emg_done = 4'b0000;
        chk("rr_cnt", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            chk("rr_0", 32'(grant_log[0]), 32'h1);
            chk("rr_1", 32'(grant_log[1]), 32'h4);
            chk("rr_2", 32'(grant_log[2]), 32'h8);
            chk("rr_3", 32'(grant_log[3]), 32'h2);
        end
        repeat (6) step();

        // Re-request of the granted N is dropped; W is queued behind it.
        grant_log.delete();
        emg_req = 4'b0001;
        step();
        emg_req = 4'b0000;
        wait_dir(4'b0001, 5);
        repeat (3) step();
        emg_req = 4'b1001;
        step();
        emg_req = 4'b0000;
        chk("ovl_pend", 32'(pending), 32'h8);
        emg_done = 4'b0001;
        wait_dir(4'b0000, 40);
        wait_dir(4'b1000, 10);
        emg_done = 4'b1000;
        wait_dir(4'b0000, 40);
        emg_done = 4'b0000;
        repeat (20) step();
        chk("ovl_cnt", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) chk("ovl_w", 32'(grant_log[1]), 32'h8);

        // Reset in cycle 10 of an S grant with E pending.
        emg_req = 4'b0010;
        step();
        emg_req = 4'b0000;
        wait_dir(4'b0010, 5);
        repeat (2) step();
        emg_req = 4'b0100;
        step();
        emg_req = 4'b0000;
        repeat (6) step();
        #1 rst_a = 1'b0;
        #1;
        chk("mid_rst_dir",  32'(emergency_dir), 32'h0);
        chk("mid_rst_pend", 32'(pending),       32'h0);
        chk("mid_rst_busy", 32'(busy),          32'h0);
        step();
        rst_a = 1'b1;
        n_grants = grant_log.size();
        repeat (30) step();
        chk("mid_rst_quiet", 32'(grant_log.size()), 32'(n_grants));

        // Random traffic against the model, with occasional resets.
        repeat (3000) begin
            step();
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) emg_req[b] = ~emg_req[b];
                emg_done[b] = ($urandom_range(0, 19) == 0);
            end
            if ($urandom_range(0, 999) == 0) begin
                rst_a = 1'b0;
                #1 rst_a = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/emergency_arbiter.md
# emergency_arbiter

Arbitrates emergency-vehicle preemption requests from the four approach sensors and drives the one-hot `emergency_dir` input of `traffic_control`. It makes sure only one direction is preempted at a time. Each grant is held for a bounded window, and an all-clear gap is inserted between consecutive grants. Simultaneous or overlapping requests are served round-robin, so no approach can starve another.

## Interface
- `HOLD_CYCLES`, default 20: minimum grant length in cycles; must be ≥1.
- `MAX_GRANT`, default 60: maximum grant length in cycles; must be ≥ `HOLD_CYCLES`.
- `CLEAR_CYCLES`, default 3: all-clear gap after each grant, in cycles; must be ≥1.
- Counter width: `$clog2(MAX_GRANT+1)`.

- `clk` input 1: single clock, rising edge.
- `rst_a` input 1: asynchronous, active-low reset.
- `emg_req` input 4: per-direction request. Bit order is bit0=N, bit1=S, bit2=E, bit3=W. Only the rising edge is significant.
- `emg_done` input 4: per-direction "vehicle cleared intersection" indication, same bit order. It is a level or a pulse.
- `emergency_dir` output 4: one-hot active grant, or 0000. Connects to `traffic_control.emergency_dir`.
- `grant_valid` output 1: high whenever `emergency_dir` ≠ 0.
- `busy` output 1: high whenever state ≠ IDLE.
- `pending` output 4: latched requests waiting for service.
- `timeout` output 1: one-cycle pulse when a grant is ended by `MAX_GRANT`.

## Operation
- **Edge detect.** `req_prev` is a register of `emg_req`. A rise is `emg_req & ~req_prev`. A rise sets the matching `pending` bit.
- **Reset interaction.** `req_prev` resets to 0, so a request that is already high when reset releases counts as a rise.
- **Re-requests.** A rise on a bit that is already pending has no effect; requests are not counted.
- **Granted direction.** A rise on the currently granted direction during GRANT is ignored and is not latched.
- **Round-robin.** `last` resets to 3 (W). The search starts at `last+1` mod 4. The first set `pending` bit wins, and `last` is updated to the winner.
- **IDLE.** If `pending` ≠ 0:
  - select the winner;
  - clear its `pending` bit;
  - load `emergency_dir` with the winner one-hot;
  - clear `cnt` and `done_seen`;
  - go to GRANT.
  - If a rise arrives on the winner's bit in the same cycle, the grant wins and the bit stays clear.
- **GRANT.**
  - `cnt` increments every cycle.
  - `emg_done[g]` sampled high sets `done_seen`. `emg_done` bits for other directions are ignored.
  - Go to CLEAR at the edge where `cnt ≥ HOLD_CYCLES-1` and (`done_seen` or `emg_done[g]`).
  - Otherwise, go to CLEAR at the edge where `cnt == MAX_GRANT-1`, and assert `timeout`.
  - On entry to CLEAR, `emergency_dir` becomes 0000 and `cnt` is cleared.
- **CLEAR.** `emergency_dir` is 0000. Rises are still latched. After `CLEAR_CYCLES` cycles, go to IDLE.
- **Reset.** Asynchronous assertion at any time, including mid-GRANT, immediately forces:
  - state IDLE;
  - `emergency_dir`=0000, `grant_valid`=0, `busy`=0, `pending`=0000, `timeout`=0;
  - `cnt`=0, `done_seen`=0, `req_prev`=0000, `last`=3.
- **Outputs.** All outputs are registered. `grant_valid` is the OR-reduce of `emergency_dir`, computed from registered state.

## Timing
- Request rise sampled at edge T: `pending` bit is set after T. If the block is in IDLE, `emergency_dir` is valid after T+1, giving 2-cycle latency. The `pending` bit clears at that same edge.
- Grant length is exactly `max(HOLD_CYCLES, k+1)` cycles, where k is the `cnt` value when done is first seen. It is capped at `MAX_GRANT`.
- Minimum spacing between grants is `CLEAR_CYCLES`+1 cycles of 0000: the CLEAR cycles plus one IDLE cycle.
- `timeout` is high for exactly the first CLEAR cycle of a timed-out grant.
- `busy` rises with the first GRANT cycle and falls on entry to IDLE.

## Test plan
All scenarios use default parameters.
1. **Reset.** Assert `rst_a`=0 between clock edges → all outputs are 0 immediately. Release, then hold inputs at 0 for 50 cycles → outputs stay 0.
2. **Single S request.** `emg_req`=0010 for one cycle sampled at T; `emg_done[1]` pulses in grant cycle 5 → `emergency_dir`=0010 from T+1 for exactly 20 cycles, then 0000. `busy` stays high for 3 further cycles; `timeout` never asserts.
3. **Timeout.** E request with no `emg_done` → `emergency_dir`=0100 for exactly 60 cycles, then `timeout` pulses for 1 cycle and `emergency_dir`=0000.
4. **Simultaneous N+E, then S+W.** `emg_req`=0101 after reset → N is granted first. E follows after the 3 CLEAR cycles plus 1 IDLE cycle. Then pulse 1010 → W is served before S, because `last`=E.
5. **Overlap.** During an N grant, pulse N and W → `pending`=1000 only. W is granted right after N's CLEAR/IDLE. No second N grant occurs.
6. **Reset mid-grant.** Assert reset in cycle 10 of an S grant → `emergency_dir`=0000 and `pending`=0000 with no clock edge. After release, no grant occurs until a new rise.
